seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a bank of common-anode 7-segment digits.

---
 rtl/seg_scan_ctrl_pkg.sv | 16 +
 rtl/seg_lz_mask.sv | 24 ++
 rtl/seg_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_ctrl_pkg;

   localparam int unsigned BCD_W = 4;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_e;

   // Larger of two sizes, used to size the shared slot counter.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero suppress mask: flags digits that should stay dark.
module seg_lz_mask
   import seg_scan_ctrl_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4
)
(
   input  logic [NUM_DIGITS-1:0][BCD_W-1:0] display,
   input  logic                             lz_en,
   output logic [NUM_DIGITS-1:0]            suppress_c
);

   // Walk down from the top digit; a digit is blank while it and all above it are zero.
   always_comb begin
      logic all_zero;
      all_zero   = 1'b1;
      suppress_c = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         all_zero      = all_zero & (display[i] == '0);
         suppress_c[i] = lz_en & all_zero;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SHOW_CYC   = 50000,
   parameter int unsigned BLANK_CYC  = 500
)
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic                        lz_en,
   input  logic                        load_valid,
   output logic                        load_ready,
   input  logic [BCD_W*NUM_DIGITS-1:0] load_data,
   output logic [BCD_W-1:0]            digit_bcd,
   output logic [NUM_DIGITS-1:0]       an_n,
   output logic                        frame_done
);

   localparam int unsigned CNT_W = $clog2(max_u(SHOW_CYC, BLANK_CYC) + 1);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF     = '1;

   typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] digits_t;

   scan_state_e      state;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] cnt;
   digits_t          display;
   digits_t          pending;
   logic             pend_valid;
   logic             en_q;

   logic             accept_c;
   logic             frame_end_c;
   logic             commit_c;
   logic [IDX_W-1:0] idx_nxt_c;
   digits_t          display_nxt;
   logic [NUM_DIGITS-1:0] suppress_c;

   seg_lz_mask #(
      .NUM_DIGITS (NUM_DIGITS)
   ) u_lz_mask (
      .display    (display),
      .lz_en      (lz_en),
      .suppress_c (suppress_c)
   );

   // Handshake, frame-end and commit decisions for this cycle.
   always_comb begin
      accept_c    = load_valid & load_ready;
      frame_end_c = en & (state == ST_SHOW) & (cnt == SHOW_LAST) & (idx == IDX_LAST);
      // While dark, a pending value lands once the display has been parked for a cycle.
      commit_c    = pend_valid & (frame_end_c | (~en & ~en_q));
      idx_nxt_c   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      display_nxt = commit_c ? pending : display;
   end

   // Scan sequencer with registered anode/digit outputs and load buffering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_BLANK;
         idx        <= '0;
         cnt        <= '0;
         display    <= '0;
         pending    <= '0;
         pend_valid <= 1'b0;
         en_q       <= 1'b0;
         an_n       <= AN_OFF;
         digit_bcd  <= '0;
         load_ready <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         en_q       <= en;
         display    <= display_nxt;
         frame_done <= frame_end_c;
         load_ready <= accept_c ? 1'b0 : ~pend_valid;
         if (accept_c) begin
            pending    <= load_data;
            pend_valid <= 1'b1;
         end else if (commit_c) begin
            pend_valid <= 1'b0;
         end

         if (!en) begin
            state     <= ST_BLANK;
            idx       <= '0;
            cnt       <= '0;
            an_n      <= AN_OFF;
            digit_bcd <= display_nxt[0];
         end else begin
            unique case (state)
               ST_BLANK: begin
                  if (cnt == BLANK_LAST) begin
                     state <= ST_SHOW;
                     cnt   <= '0;
                     an_n  <= suppress_c[idx] ? AN_OFF : ~(NUM_DIGITS'(1) << idx);
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               ST_SHOW: begin
                  if (cnt == SHOW_LAST) begin
                     state     <= ST_BLANK;
                     cnt       <= '0;
                     idx       <= idx_nxt_c;
                     an_n      <= AN_OFF;
                     digit_bcd <= display_nxt[idx_nxt_c];
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 4 show cycles, 2 blank cycles).
module tb_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int SHOW  = 4;
   localparam int BLANK = 2;
   localparam int SLOT  = SHOW + BLANK;
   localparam int FRAME = ND * SLOT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en;
   logic        lz_en;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic [3:0]  digit_bcd;
   logic [3:0]  an_n;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   seg_scan_ctrl #(
      .NUM_DIGITS (ND),
      .SHOW_CYC   (SHOW),
      .BLANK_CYC  (BLANK)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .lz_en      (lz_en),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .digit_bcd  (digit_bcd),
      .an_n       (an_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic [3:0] an;
      logic [3:0] bcd;
      logic       ready;
      logic       fd;
   } exp_t;

   exp_t        sb_q[$];
   int          m_pos;
   logic [15:0] m_disp, m_pend;
   logic [3:0]  m_an;
   bit          m_pv, m_ready, m_fd, m_enp, m_jc;

   function automatic bit m_sup(input logic [15:0] d, input int s, input bit lz);
      if (!lz || s == 0) return 1'b0;
      for (int k = s; k < ND; k++)
         if (d[4*k +: 4] != 4'h0) return 1'b0;
      return 1'b1;
   endfunction

   initial begin
      forever begin
         bit acc, fe, cm;
         int np;
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_pos = 0; m_disp = '0; m_pend = '0; m_an = 4'hF;
            m_pv = 0; m_ready = 1; m_fd = 0; m_enp = 0; m_jc = 0;
            sb_q.delete();
            sb_q.push_back('{an: 4'hF, bcd: 4'h0, ready: 1'b1, fd: 1'b0});
         end else begin
            acc = load_valid && m_ready;
            fe  = en && (m_pos == FRAME - 1);
            cm  = m_pv && (fe || (!en && !m_enp));
            np  = en ? (fe ? 0 : m_pos + 1) : 0;
            if (!en || (np % SLOT) < BLANK) m_an = 4'hF;
            else if ((np % SLOT) == BLANK)
               m_an = m_sup(m_disp, np / SLOT, lz_en) ? 4'hF : 4'(~(4'b0001 << (np / SLOT)));
            m_ready = acc ? 1'b0 : (m_ready | m_jc);
            m_jc    = cm;
            if (cm) begin m_disp = m_pend; m_pv = 0; end
            if (acc) begin m_pend = load_data; m_pv = 1; end
            m_fd  = fe;
            m_enp = en;
            m_pos = np;
            sb_q.push_back('{an: m_an, bcd: m_disp[4*(np/SLOT) +: 4], ready: m_ready, fd: m_fd});
         end
      end
   end

   initial begin
      forever begin
         exp_t e;
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({an_n, digit_bcd, load_ready, frame_done} !== {e.an, e.bcd, e.ready, e.fd}) begin
               errors++;
               $display("FAIL scoreboard t=%0t: got an_n=%h bcd=%h ready=%b fd=%b, expected an_n=%h bcd=%h ready=%b fd=%b",
                        $time, an_n, digit_bcd, load_ready, frame_done, e.an, e.bcd, e.ready, e.fd);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic offer(input logic [15:0] d);
      int n;
      n = 0;
      while (!load_ready && n < 100) begin @(negedge clk); n++; end
      chk("offer_ready", 32'(load_ready), 32'd1);
      load_valid = 1'b1;
      load_data  = d;
      @(negedge clk);
      chk("ready_drop", 32'(load_ready), 32'd0);
      load_valid = 1'b0;
      load_data  = 16'($urandom);
   endtask

   task automatic wait_fd(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!frame_done && n < 100) begin @(negedge clk); n++; end
      chk(name, 32'(frame_done), 32'd1);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct packed {
      logic [15:0]      data;
      logic             lz;
      logic [3:0][3:0]  an;   // an[slot] while that slot's digit is lit
      logic [3:0][3:0]  bcd;  // digit_bcd during slot
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n;
      logic [3:0] prev;

      vecs[0] = '{data: 16'h4321, lz: 1'b0, an: 16'h7BDE, bcd: 16'h4321};
      vecs[1] = '{data: 16'h0000, lz: 1'b1, an: 16'hFFFE, bcd: 16'h0000};
      vecs[2] = '{data: 16'h0050, lz: 1'b1, an: 16'hFFDE, bcd: 16'h0050};
      vecs[3] = '{data: 16'h0050, lz: 1'b0, an: 16'h7BDE, bcd: 16'h0050};
      vecs[4] = '{data: 16'h9007, lz: 1'b1, an: 16'h7BDE, bcd: 16'h9007};
      vecs[5] = '{data: 16'h0300, lz: 1'b1, an: 16'hFBDE, bcd: 16'h0300};

      en = 1'b0; lz_en = 1'b0; load_valid = 1'b0; load_data = '0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_an_n", 32'(an_n), 32'hF);
      chk("rst_digit", 32'(digit_bcd), 32'h0);
      chk("rst_ready", 32'(load_ready), 32'd1);
      chk("rst_fd", 32'(frame_done), 32'd0);
      rst_n = 1'b1;
      en    = 1'b1;

      // Table: load, wait for commit, then walk one full frame slot by slot.
      for (int r = 0; r < 6; r++) begin
         lz_en = vecs[r].lz;
         offer(vecs[r].data);
         wait_fd("vec_commit");
         for (int c = 0; c < FRAME; c++) begin
            chk("vec_an_n", 32'(an_n), ((c % SLOT) < BLANK) ? 32'hF : 32'(vecs[r].an[c / SLOT]));
            chk("vec_digit", 32'(digit_bcd), 32'(vecs[r].bcd[c / SLOT]));
            if (c == 1) chk("vec_ready_back", 32'(load_ready), 32'd1);
            @(negedge clk);
         end
         chk("vec_period", 32'(frame_done), 32'd1);
      end

      // load_valid held across frames; data sampled only on accept.
      load_valid = 1'b1;
      load_data  = 16'h1111;
      @(negedge clk);
      chk("hold_ready_drop", 32'(load_ready), 32'd0);
      load_data = 16'h2222;
      wait_fd("hold_fd1");
      chk("hold_commit1", 32'(digit_bcd), 32'h1);
      chk("hold_ready_fd1", 32'(load_ready), 32'd0);
      @(negedge clk);
      chk("hold_ready_back1", 32'(load_ready), 32'd1);
      @(negedge clk);
      chk("hold_ready_drop2", 32'(load_ready), 32'd0);
      load_valid = 1'b0;
      load_data  = 16'h3333;
      wait_fd("hold_fd2");
      chk("hold_commit2", 32'(digit_bcd), 32'h2);
      @(negedge clk);
      chk("hold_ready_back2", 32'(load_ready), 32'd1);

      // Drop en during digit 2's SHOW with a load pending.
      offer(16'h8765);
      n = 0;
      while (an_n != 4'b1011 && n < 100) begin @(negedge clk); n++; end
      chk("reach_digit2", 32'(an_n), 32'hB);
      en = 1'b0;
      @(negedge clk);
      chk("en_off_an", 32'(an_n), 32'hF);
      chk("en_off_digit_old", 32'(digit_bcd), 32'h2);
      chk("en_off_ready", 32'(load_ready), 32'd0);
      @(negedge clk);
      chk("en_off_commit", 32'(digit_bcd), 32'h5);
      chk("en_off_fd", 32'(frame_done), 32'd0);
      @(negedge clk);
      chk("en_off_ready_back", 32'(load_ready), 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("en_off_dark", 32'(an_n), 32'hF);
      end
      en = 1'b1;
      @(negedge clk);
      chk("reen_blank", 32'(an_n), 32'hF);
      @(negedge clk);
      chk("reen_show", 32'(an_n), 32'hE);
      chk("reen_digit", 32'(digit_bcd), 32'h5);

      // Reset pulse mid-frame with a load pending.
      offer(16'h9999);
      n = 0;
      while (an_n == 4'hF && n < 100) begin @(negedge clk); n++; end
      chk("rst_mid_lit", 32'(an_n != 4'hF), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_an", 32'(an_n), 32'hF);
      chk("rst_mid_digit", 32'(digit_bcd), 32'h0);
      chk("rst_mid_ready", 32'(load_ready), 32'd1);
      chk("rst_mid_fd", 32'(frame_done), 32'd0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      wait_fd("rst_fd");
      chk("rst_pend_lost", 32'(digit_bcd), 32'h0);
      chk("rst_ready_after", 32'(load_ready), 32'd1);

      // Ten frames: period and anode-safety checks.
      prev = an_n;
      for (int f = 0; f < 10; f++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
            chk("an_onehot", 32'($countones(~an_n) <= 1), 32'd1);
            chk("an_no_direct", 32'(prev != 4'hF && an_n != 4'hF && an_n != prev), 32'd0);
            prev = an_n;
         end while (!frame_done && n < 100);
         chk("fd_period", 32'(n), 32'(FRAME));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
